// File: rtl/serial_sub.sv
// Bit-serial unsigned subtractor: Diff = A - B over WIDTH bits, one bit per clock, LSB first.
// Operands are captured on an accepted start; Diff/Bout update only at completion, with a one-cycle done.
module serial_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_work;
  logic [WIDTH-1:0] r_diff;
  logic             r_borrow;
  logic             r_bout;
  logic [CW-1:0]    r_count;

  logic             w_accept;
  logic             w_last;
  logic             w_a;
  logic             w_b;
  logic             w_d;
  logic             w_borrow_next;
  logic [WIDTH-1:0] w_work_next;

  assign w_last        = (r_count == CW'(WIDTH - 1));
  assign w_a           = r_a_sr[0];
  assign w_b           = r_b_sr[0];
  assign w_d           = w_a ^ w_b ^ r_borrow;
  assign w_borrow_next = (~w_a & w_b) | (~(w_a ^ w_b) & r_borrow);
  assign w_work_next   = {w_d, r_work[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // start is only honoured while not busy (IDLE or the DONE cycle)
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_next = S_SHIFT;
          w_accept     = 1'b1;
        end
      end
      S_SHIFT: begin
        if (w_last) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        if (start) begin
          w_state_next = S_SHIFT;
          w_accept     = 1'b1;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sr   <= '0;
      r_b_sr   <= '0;
      r_work   <= '0;
      r_borrow <= 1'b0;
      r_count  <= '0;
      r_diff   <= '0;
      r_bout   <= 1'b0;
    end else if (w_accept) begin
      r_a_sr   <= A;
      r_b_sr   <= B;
      r_work   <= '0;
      r_borrow <= 1'b0;
      r_count  <= '0;
    end else if (r_state == S_SHIFT) begin
      r_a_sr   <= r_a_sr >> 1;
      r_b_sr   <= r_b_sr >> 1;
      r_work   <= w_work_next;
      r_borrow <= w_borrow_next;
      r_count  <= r_count + 1'b1;
      // The published result includes this cycle's bit and borrow
      if (w_last) begin
        r_diff <= w_work_next;
        r_bout <= w_borrow_next;
      end
    end
  end

  assign Diff = r_diff;
  assign Bout = r_bout;
  assign busy = (r_state == S_SHIFT);
  assign done = (r_state == S_DONE);

endmodule
